// File: rtl/commit_trace_collector.sv
// Commit trace collector: records memory and register write events from the core as
// timestamped entries in a small FIFO, drained by a host/debug reader over valid/ready.
// Events from one cycle are pushed together or dropped together; drops are counted.
module commit_trace_collector #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   capture_en,
    input  logic                   mem_we,
    input  logic [DATA_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_wdata,
    input  logic                   reg_we,
    input  logic [3:0]             reg_idx,
    input  logic [DATA_W-1:0]      reg_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_kind,
    output logic [TS_W-1:0]        out_ts,
    output logic [DATA_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_count
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned CW1 = CNT_W + 1;

    localparam logic [LW-1:0]    DepthLvl = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    // Entry storage, one array per field
    logic              kind_mem [DEPTH];
    logic [TS_W-1:0]   ts_mem   [DEPTH];
    logic [DATA_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // Control state
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    // Per-cycle decode
    logic          pop;
    logic          ev_mem, ev_reg;
    logic [1:0]    n_ev;
    logic [1:0]    n_push;
    logic [LW-1:0] free;
    logic          fits;
    logic          push_mem, push_reg;
    logic          drop;
    logic [AW-1:0] reg_slot;
    logic [CW1-1:0] drop_sum;

    // Head slot drives the output port directly
    assign out_valid  = (level_q != '0);
    assign out_kind   = kind_mem[rd_ptr_q];
    assign out_ts     = ts_mem[rd_ptr_q];
    assign out_addr   = addr_mem[rd_ptr_q];
    assign out_data   = data_mem[rd_ptr_q];
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

    // Event decode and all-or-nothing admission against the space freed by a same-cycle pop
    always_comb begin
        pop      = out_valid & out_ready;
        ev_mem   = mem_we & capture_en;
        ev_reg   = reg_we & capture_en;
        n_ev     = {1'b0, ev_mem} + {1'b0, ev_reg};
        free     = DepthLvl - level_q + LW'(pop);
        fits     = (LW'(n_ev) <= free);
        push_mem = ev_mem & fits;
        push_reg = ev_reg & fits;
        drop     = (n_ev != 2'd0) & ~fits;
        n_push   = fits ? n_ev : 2'd0;
        // Register entry lands behind the memory entry when both are pushed
        reg_slot = wr_ptr_q + AW'(push_mem);
    end

    // Next-state for pointers, level, timestamp and drop accounting; clear overrides all
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        ts_d       = ts_q + TS_W'(1);
        overflow_d = overflow_q;
        drop_d     = drop_q;
        drop_sum   = {1'b0, drop_q} + CW1'(n_ev);
        if (clear) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            ts_d       = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(n_push);
            level_d  = level_q + LW'(n_push) - LW'(pop);
            if (drop) begin
                overflow_d = 1'b1;
                drop_d     = drop_sum[CNT_W] ? CntMax : drop_sum[CNT_W-1:0];
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Entry writes; storage is reset so the output fields read zero out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                kind_mem[i] <= 1'b0;
                ts_mem[i]   <= '0;
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (!clear) begin
            if (push_mem) begin
                kind_mem[wr_ptr_q] <= 1'b0;
                ts_mem[wr_ptr_q]   <= ts_q;
                addr_mem[wr_ptr_q] <= mem_addr;
                data_mem[wr_ptr_q] <= mem_wdata;
            end
            if (push_reg) begin
                kind_mem[reg_slot] <= 1'b1;
                ts_mem[reg_slot]   <= ts_q;
                addr_mem[reg_slot] <= {{(DATA_W-4){1'b0}}, reg_idx};
                data_mem[reg_slot] <= reg_wdata;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_collector.sv
// Self-checking bench for commit_trace_collector: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_commit_trace_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        capture_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        reg_we;
    logic [3:0]  reg_idx;
    logic [31:0] reg_wdata;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [15:0] out_ts;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    commit_trace_collector dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .capture_en (capture_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .reg_we     (reg_we),
        .reg_idx    (reg_idx),
        .reg_wdata  (reg_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kind   (out_kind),
        .out_ts     (out_ts),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        kind;
        bit [15:0] ts;
        bit [31:0] addr;
        bit [31:0] data;
    } entry_t;

    entry_t      mq[$];
    int unsigned m_ts;
    int unsigned m_drops;
    bit          m_ovf;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, from the current inputs
    task automatic model_step();
        int unsigned n;
        int unsigned free;
        bit          p;
        entry_t      e;
        if (clear) begin
            mq.delete();
            m_ts    = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
            return;
        end
        n    = int'(mem_we && capture_en) + int'(reg_we && capture_en);
        p    = (mq.size() != 0) && out_ready;
        free = 16 - mq.size() + int'(p);
        if (p) void'(mq.pop_front());
        if (n <= free) begin
            if (mem_we && capture_en) begin
                e.kind = 1'b0; e.ts = m_ts[15:0]; e.addr = mem_addr; e.data = mem_wdata;
                mq.push_back(e);
            end
            if (reg_we && capture_en) begin
                e.kind = 1'b1; e.ts = m_ts[15:0]; e.addr = {28'd0, reg_idx}; e.data = reg_wdata;
                mq.push_back(e);
            end
        end else begin
            m_drops = (m_drops + n > 65535) ? 65535 : m_drops + n;
            m_ovf   = 1'b1;
        end
        m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic compare_model();
        check_eq("level", level, mq.size());
        check_eq("valid", out_valid, mq.size() != 0);
        check_eq("overflow", overflow, m_ovf);
        check_eq("drop_count", drop_count, m_drops);
        if (mq.size() != 0) begin
            check_eq("head_kind", out_kind, mq[0].kind);
            check_eq("head_ts", out_ts, mq[0].ts);
            check_eq("head_addr", out_addr, mq[0].addr);
            check_eq("head_data", out_data, mq[0].data);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input bit en, input bit mw, input bit rw, input bit rdy);
        clear      = 1'b0;
        capture_en = en;
        mem_we     = mw;
        reg_we     = rw;
        out_ready  = rdy;
        mem_addr   = $urandom;
        mem_wdata  = $urandom;
        reg_idx    = 4'($urandom);
        reg_wdata  = $urandom;
    endtask

    // Asynchronous reset: state must be empty before any clock edge
    task automatic do_reset();
        reset = 1'b0;
        #2;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_drops", drop_count, 0);
        check_eq("rst_out_fields", {out_kind, out_ts, out_addr[15:0], out_data[15:0]}, 0);
        mq.delete();
        m_ts    = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int unsigned t2ts;
        int unsigned phase;
        reset = 1'b0;
        drive(0, 0, 0, 0);
        do_reset();

        // T1: single memory write stamped with ts=5
        repeat (5) tick();
        drive(1, 1, 0, 0);
        mem_addr  = 32'h100;
        mem_wdata = 32'hDEAD;
        tick();
        check_eq("t1_valid", out_valid, 1);
        check_eq("t1_kind", out_kind, 0);
        check_eq("t1_ts", out_ts, 5);
        check_eq("t1_addr", out_addr, 32'h100);
        check_eq("t1_data", out_data, 32'hDEAD);
        check_eq("t1_level", level, 1);
        drive(1, 0, 0, 1);
        tick();

        // T2: simultaneous memory + register writes
        drive(1, 1, 1, 0);
        reg_idx   = 4'd3;
        reg_wdata = 32'h55;
        t2ts      = m_ts;
        tick();
        check_eq("t2_level", level, 2);
        check_eq("t2_first_kind", out_kind, 0);
        check_eq("t2_first_ts", out_ts, t2ts);
        drive(1, 0, 0, 1);
        tick();
        check_eq("t2_second_kind", out_kind, 1);
        check_eq("t2_second_addr", out_addr, 3);
        check_eq("t2_second_data", out_data, 32'h55);
        check_eq("t2_second_ts", out_ts, t2ts);
        tick();

        // T3: full FIFO drops a dual event, then accepts a single one with a pop
        repeat (8) begin drive(1, 1, 1, 0); tick(); end
        check_eq("t3_full", level, 16);
        drive(1, 1, 1, 0);
        tick();
        check_eq("t3_drops", drop_count, 2);
        check_eq("t3_overflow", overflow, 1);
        check_eq("t3_level_after_drop", level, 16);
        drive(1, 1, 0, 1);
        tick();
        check_eq("t3_level_pop_push", level, 16);
        check_eq("t3_drops_unchanged", drop_count, 2);

        // T4: level 15, dual event with no pop is dropped whole
        drive(1, 0, 0, 1);
        tick();
        drive(1, 1, 1, 0);
        tick();
        check_eq("t4_level", level, 15);
        check_eq("t4_drops", drop_count, 4);

        // T5: backpressure holds the head, then 16 pops drain in order
        drive(1, 0, 1, 0);
        tick();
        repeat (10) begin drive(0, 1'($urandom), 1'($urandom), 0); tick(); end
        repeat (16) begin drive(0, 1'($urandom), 1'($urandom), 1); tick(); end
        check_eq("t5_drained", level, 0);

        // T6: clear with level 7 and drop_count 3; next event is stamped ts=0
        drive(0, 0, 0, 0);
        clear = 1'b1;
        tick();
        repeat (8) begin drive(1, 1, 1, 0); tick(); end
        drive(1, 1, 1, 0);
        tick();
        drive(1, 0, 1, 0);
        tick();
        repeat (9) begin drive(1, 0, 0, 1); tick(); end
        check_eq("t6_pre_level", level, 7);
        check_eq("t6_pre_drops", drop_count, 3);
        drive(1, 1, 1, 1);
        clear = 1'b1;
        tick();
        check_eq("t6_clr_level", level, 0);
        check_eq("t6_clr_drops", drop_count, 0);
        check_eq("t6_clr_overflow", overflow, 0);
        drive(1, 1, 0, 0);
        tick();
        check_eq("t6_ts_zero", out_ts, 0);

        // Drop counter saturation
        drive(0, 0, 0, 0);
        clear = 1'b1;
        tick();
        repeat (8) begin drive(1, 1, 1, 0); tick(); end
        repeat (32800) begin drive(1, 1, 1, 0); tick(); end
        check_eq("sat_drops", drop_count, 16'hFFFF);

        // Randomized traffic with occasional clears and one mid-burst reset
        drive(0, 0, 0, 0);
        clear = 1'b1;
        tick();
        for (int i = 0; i < 3000; i++) begin
            phase = (i / 300) % 5;
            drive(($urandom % 8) != 0, 1'($urandom), 1'($urandom), ($urandom % 4) < phase);
            clear = (($urandom % 97) == 0);
            if (i == 1500) begin
                #1;
                do_reset();
                drive(1, 1, 1, 0);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
